// File: rtl/smem_result_buffer.sv
// Per-read curr/mem interval queue store with size/ret tables and a batched
// 512-bit valid/ready result stream (one header beat per read, two mem entries per body beat).
module smem_result_buffer #(
    parameter int READ_NUM_W = 8,
    parameter int SLOT_W     = 7,
    parameter int RET_W      = 7
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [READ_NUM_W:0]   batch_size,
    input  logic                  curr_we,
    input  logic [READ_NUM_W-1:0] curr_wr_read,
    input  logic [SLOT_W-1:0]     curr_wr_addr,
    input  logic [255:0]          curr_wr_data,
    input  logic                  curr_rd_en,
    input  logic [READ_NUM_W-1:0] curr_rd_read,
    input  logic [SLOT_W-1:0]     curr_rd_addr,
    output logic [255:0]          curr_rd_data,
    input  logic                  mem_we,
    input  logic                  mem_rd_en,
    input  logic [READ_NUM_W-1:0] mem_read,
    input  logic [SLOT_W-1:0]     mem_addr,
    input  logic [255:0]          mem_wr_data,
    output logic [255:0]          mem_rd_data,
    input  logic                  size_valid,
    input  logic [READ_NUM_W-1:0] size_read,
    input  logic [RET_W-1:0]      size_val,
    input  logic                  ret_valid,
    input  logic [READ_NUM_W-1:0] ret_read,
    input  logic [RET_W-1:0]      ret_val,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [511:0]          out_data,
    output logic                  out_last,
    output logic                  out_finish,
    output logic                  busy
);

    localparam int NREAD = 1 << READ_NUM_W;
    localparam int DEPTH = 1 << (READ_NUM_W + SLOT_W);
    localparam int CW    = ((SLOT_W > RET_W) ? SLOT_W : RET_W) + 1;

    typedef enum logic [2:0] {IDLE, WAIT_DONE, HEADER, BODY, NEXT, FINISH} state_t;

    // Only the meaningful fields of an entry are kept: [230:224],[198:192],[160:128],[96:64],[32:0]
    function automatic logic [112:0] compact(input logic [255:0] e);
        return {e[230:224], e[198:192], e[160:128], e[96:64], e[32:0]};
    endfunction

    function automatic logic [255:0] expand(input logic [112:0] c);
        logic [255:0] e;
        e            = '0;
        e[32:0]      = c[32:0];
        e[96:64]     = c[65:33];
        e[160:128]   = c[98:66];
        e[198:192]   = c[105:99];
        e[230:224]   = c[112:106];
        return e;
    endfunction

    logic [112:0]          curr_q [DEPTH];
    logic [112:0]          mem_q  [DEPTH];
    logic [RET_W-1:0]      size_tbl [NREAD];
    logic [RET_W-1:0]      ret_tbl  [NREAD];
    logic [NREAD-1:0]      done_map;
    logic [READ_NUM_W:0]   done_count, batch_q;

    state_t                state, state_nxt;
    logic [READ_NUM_W-1:0] cur_read, read_nxt;
    logic [SLOT_W-1:0]     cur_k, k_nxt, k_hi;
    logic [RET_W-1:0]      cur_size, cur_ret;
    logic                  start_ok, fire, adv, is_hdr, s0_valid;
    logic                  read_end, upper_empty, last_read;

    logic                  s1_valid, s1_hdr, s1_upper_empty, s1_last;
    logic [READ_NUM_W-1:0] s1_read;
    logic [RET_W-1:0]      s1_size, s1_ret;
    logic [112:0]          ent_lo, ent_hi;
    logic [511:0]          beat;
    logic                  unused_wr_bits;

    assign unused_wr_bits = ^{curr_wr_data[255:231], curr_wr_data[223:199], curr_wr_data[191:161],
                              curr_wr_data[127:97], curr_wr_data[63:33],
                              mem_wr_data[255:231], mem_wr_data[223:199], mem_wr_data[191:161],
                              mem_wr_data[127:97], mem_wr_data[63:33]};

    always_ff @(posedge clk) begin
        if (curr_we) curr_q[{curr_wr_read, curr_wr_addr}] <= compact(curr_wr_data);
        if (mem_we)  mem_q[{mem_read, mem_addr}]          <= compact(mem_wr_data);
        if (size_valid) size_tbl[size_read] <= size_val;
        if (ret_valid)  ret_tbl[ret_read]   <= ret_val;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            curr_rd_data <= '0;
            mem_rd_data  <= '0;
        end else begin
            if (curr_rd_en) curr_rd_data <= expand(curr_q[{curr_rd_read, curr_rd_addr}]);
            if (mem_rd_en)  mem_rd_data  <= expand(mem_q[{mem_read, mem_addr}]);
        end
    end

    assign start_ok = start && !busy;
    assign fire     = out_valid && out_ready;
    assign adv      = !out_valid || out_ready;

    // A read counts toward completion only on its first size report
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            done_map   <= '0;
            done_count <= '0;
            batch_q    <= '0;
        end else if (start_ok) begin
            done_map   <= '0;
            done_count <= '0;
            batch_q    <= batch_size;
        end else if (size_valid && !done_map[size_read]) begin
            done_map[size_read] <= 1'b1;
            done_count          <= done_count + (READ_NUM_W+1)'(1);
        end
    end

    // Stage 0 is the cursor: the FSM state says whether it points at a header or a body pair
    assign cur_size    = size_tbl[cur_read];
    assign cur_ret     = ret_tbl[cur_read];
    assign is_hdr      = (state == HEADER);
    assign s0_valid    = (state == HEADER) || (state == BODY);
    assign k_hi        = cur_k + SLOT_W'(1);
    assign read_end    = is_hdr ? (cur_size == '0) : ((CW'(cur_k) + CW'(2)) >= CW'(cur_size));
    assign upper_empty = (CW'(cur_k) + CW'(1)) >= CW'(cur_size);
    assign last_read   = ({1'b0, cur_read} == (batch_q - (READ_NUM_W+1)'(1)));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            cur_read <= '0;
            cur_k    <= '0;
        end else begin
            state    <= state_nxt;
            cur_read <= read_nxt;
            cur_k    <= k_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        read_nxt  = cur_read;
        k_nxt     = cur_k;
        case (state)
            IDLE, FINISH: if (start_ok) state_nxt = WAIT_DONE;
            WAIT_DONE: begin
                if (batch_q == '0) begin
                    state_nxt = FINISH;
                end else if (done_count == batch_q) begin
                    state_nxt = HEADER;
                    read_nxt  = '0;
                    k_nxt     = '0;
                end
            end
            HEADER, BODY: begin
                if (adv) begin
                    if (!read_end) begin
                        state_nxt = BODY;
                        k_nxt     = is_hdr ? '0 : cur_k + SLOT_W'(2);
                    end else if (last_read) begin
                        state_nxt = NEXT;
                    end else begin
                        state_nxt = HEADER;
                        read_nxt  = cur_read + READ_NUM_W'(1);
                        k_nxt     = '0;
                    end
                end
            end
            NEXT: if (fire && out_last) state_nxt = FINISH;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy       <= 1'b0;
            out_finish <= 1'b0;
        end else if (start_ok) begin
            busy       <= 1'b1;
            out_finish <= 1'b0;
        end else if ((state == WAIT_DONE && batch_q == '0) || (state == NEXT && fire && out_last)) begin
            busy       <= 1'b0;
            out_finish <= 1'b1;
        end
    end

    // Output-side read ports; they advance in lockstep with the pipeline so a stall freezes them
    always_ff @(posedge clk) begin
        if (adv) begin
            ent_lo <= mem_q[{cur_read, cur_k}];
            ent_hi <= mem_q[{cur_read, k_hi}];
        end
    end

    always_comb begin
        beat = '0;
        if (s1_valid) begin
            if (s1_hdr) begin
                beat[READ_NUM_W-1:0] = s1_read;
                beat[64 +: RET_W]    = s1_size;
                beat[128 +: RET_W]   = s1_ret;
            end else begin
                beat[255:0]   = expand(ent_lo);
                beat[511:256] = s1_upper_empty ? 256'd0 : expand(ent_hi);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid       <= 1'b0;
            s1_hdr         <= 1'b0;
            s1_upper_empty <= 1'b0;
            s1_last        <= 1'b0;
            s1_read        <= '0;
            s1_size        <= '0;
            s1_ret         <= '0;
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
            out_data       <= '0;
        end else if (adv) begin
            s1_valid       <= s0_valid;
            s1_hdr         <= is_hdr;
            s1_upper_empty <= upper_empty;
            s1_last        <= s0_valid && read_end && last_read;
            s1_read        <= cur_read;
            s1_size        <= cur_size;
            s1_ret         <= cur_ret;
            out_valid      <= s1_valid;
            out_last       <= s1_valid && s1_last;
            out_data       <= beat;
        end
    end

endmodule

// File: tb/tb_smem_result_buffer.sv
// Directed testbench for smem_result_buffer: compaction, read ports, streaming,
// duplicate sizes, backpressure, empty batch, busy start and mid-stream reset.
module tb_smem_result_buffer;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [8:0]   batch_size;
    logic         curr_we;
    logic [7:0]   curr_wr_read;
    logic [6:0]   curr_wr_addr;
    logic [255:0] curr_wr_data;
    logic         curr_rd_en;
    logic [7:0]   curr_rd_read;
    logic [6:0]   curr_rd_addr;
    logic [255:0] curr_rd_data;
    logic         mem_we;
    logic         mem_rd_en;
    logic [7:0]   mem_read;
    logic [6:0]   mem_addr;
    logic [255:0] mem_wr_data;
    logic [255:0] mem_rd_data;
    logic         size_valid;
    logic [7:0]   size_read;
    logic [6:0]   size_val;
    logic         ret_valid;
    logic [7:0]   ret_read;
    logic [6:0]   ret_val;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] out_data;
    logic         out_last;
    logic         out_finish;
    logic         busy;

    int           checks = 0;
    int           errors = 0;
    logic [511:0] got [16];
    logic         got_last [16];
    int           got_n;
    int           got_gaps;
    logic         got_timeout;

    smem_result_buffer #(.READ_NUM_W(8), .SLOT_W(7), .RET_W(7)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .batch_size(batch_size),
        .curr_we(curr_we), .curr_wr_read(curr_wr_read), .curr_wr_addr(curr_wr_addr),
        .curr_wr_data(curr_wr_data), .curr_rd_en(curr_rd_en), .curr_rd_read(curr_rd_read),
        .curr_rd_addr(curr_rd_addr), .curr_rd_data(curr_rd_data),
        .mem_we(mem_we), .mem_rd_en(mem_rd_en), .mem_read(mem_read), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
        .size_valid(size_valid), .size_read(size_read), .size_val(size_val),
        .ret_valid(ret_valid), .ret_read(ret_read), .ret_val(ret_val),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_finish(out_finish), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [255:0] sq(input logic [255:0] e);
        logic [255:0] m;
        m = '0;
        m[230:224] = '1;
        m[198:192] = '1;
        m[160:128] = '1;
        m[96:64]   = '1;
        m[32:0]    = '1;
        return e & m;
    endfunction

    function automatic logic [255:0] pat(input int i);
        return {64'hF0E1_D2C3_B4A5_9687 ^ 64'(i), 64'h0123_4567_89AB_CDEF + 64'(i),
                64'hFFFF_FFFF_FFFF_FFFF - 64'(i), 64'hDEAD_BEEF_CAFE_F00D ^ (64'(i) << 8)};
    endfunction

    function automatic logic [511:0] hdr(input logic [7:0] r, input logic [6:0] s, input logic [6:0] t);
        logic [511:0] h;
        h          = '0;
        h[7:0]     = r;
        h[70:64]   = s;
        h[134:128] = t;
        return h;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [8:0] n);
        start      = 1'b1;
        batch_size = n;
        tick;
        start      = 1'b0;
    endtask

    task automatic report(input int r, input int s, input int t);
        size_valid = 1'b1;
        size_read  = 8'(r);
        size_val   = 7'(s);
        ret_valid  = 1'b1;
        ret_read   = 8'(r);
        ret_val    = 7'(t);
        tick;
        size_valid = 1'b0;
        ret_valid  = 1'b0;
    endtask

    task automatic write_mem(input int r, input int slot, input logic [255:0] d);
        mem_we      = 1'b1;
        mem_read    = 8'(r);
        mem_addr    = 7'(slot);
        mem_wr_data = d;
        tick;
        mem_we      = 1'b0;
    endtask

    // Drains the stream with out_ready high, recording beats until out_finish or the budget runs out
    task automatic collect(input int budget);
        got_n       = 0;
        got_gaps    = 0;
        got_timeout = 1'b1;
        out_ready   = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (out_finish) begin
                got_timeout = 1'b0;
                break;
            end
            if (out_valid) begin
                if (got_n < 16) begin
                    got[got_n]      = out_data;
                    got_last[got_n] = out_last;
                end
                got_n++;
            end else if (got_n > 0) begin
                got_gaps++;
            end
            tick;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick;
        tick;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_last: got %b expected 0", out_last); end
        checks++; if (out_finish !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_finish: got %b expected 0", out_finish); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (out_data !== 512'd0) begin errors++; $display("[TB] FAIL reset_out_data: got %0h expected 0", out_data); end
        checks++; if (curr_rd_data !== 256'd0) begin errors++; $display("[TB] FAIL reset_curr_rd: got %0h expected 0", curr_rd_data); end
        checks++; if (mem_rd_data !== 256'd0) begin errors++; $display("[TB] FAIL reset_mem_rd: got %0h expected 0", mem_rd_data); end
        reset_n = 1'b1;
        tick;
    endtask

    task automatic test_compaction;
        logic [255:0] exp_c;
        exp_c        = sq({256{1'b1}});
        curr_we      = 1'b1;
        curr_wr_read = 8'd3;
        curr_wr_addr = 7'd5;
        curr_wr_data = {256{1'b1}};
        tick;
        curr_we      = 1'b0;
        curr_rd_en   = 1'b1;
        curr_rd_read = 8'd3;
        curr_rd_addr = 7'd5;
        tick;
        curr_rd_en   = 1'b0;
        checks++; if (curr_rd_data !== exp_c) begin errors++; $display("[TB] FAIL compaction: got %0h expected %0h", curr_rd_data, exp_c); end
        // overwrite the slot without reading: the port must hold its last value
        curr_we      = 1'b1;
        curr_wr_data = 256'd0;
        tick;
        curr_we      = 1'b0;
        tick;
        checks++; if (curr_rd_data !== exp_c) begin errors++; $display("[TB] FAIL curr_hold: got %0h expected %0h", curr_rd_data, exp_c); end
        write_mem(3, 5, pat(7));
        mem_we      = 1'b1;
        mem_wr_data = pat(8);
        mem_rd_en   = 1'b1;
        tick;
        mem_we      = 1'b0;
        checks++; if (mem_rd_data !== sq(pat(7))) begin errors++; $display("[TB] FAIL mem_read_old: got %0h expected %0h", mem_rd_data, sq(pat(7))); end
        tick;
        mem_rd_en   = 1'b0;
        checks++; if (mem_rd_data !== sq(pat(8))) begin errors++; $display("[TB] FAIL mem_read_new: got %0h expected %0h", mem_rd_data, sq(pat(8))); end
    endtask

    task automatic test_basic_stream;
        logic [511:0] exp_b [4];
        int           lat;
        exp_b[0] = hdr(8'd0, 7'd3, 7'd9);
        exp_b[1] = {sq(pat(1)), sq(pat(0))};
        exp_b[2] = {256'd0, sq(pat(2))};
        exp_b[3] = hdr(8'd1, 7'd0, 7'd5);
        for (int i = 0; i < 3; i++) write_mem(0, i, pat(i));
        out_ready = 1'b1;
        do_start(9'd2);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy: got %b expected 1", busy); end
        report(0, 3, 9);
        report(1, 0, 5);
        lat = 0;
        while (!out_valid && lat < 10) begin
            tick;
            lat++;
        end
        checks++; if (lat > 3) begin errors++; $display("[TB] FAIL basic_latency: got %0d cycles expected at most 3", lat); end
        collect(20);
        checks++; if (got_timeout !== 1'b0) begin errors++; $display("[TB] FAIL basic_timeout: got %b expected 0", got_timeout); end
        checks++; if (got_n != 4) begin errors++; $display("[TB] FAIL basic_beats: got %0d expected 4", got_n); end
        checks++; if (got_gaps != 0) begin errors++; $display("[TB] FAIL basic_gaps: got %0d expected 0", got_gaps); end
        for (int i = 0; i < 4 && i < got_n; i++) begin
            checks++; if (got[i] !== exp_b[i]) begin errors++; $display("[TB] FAIL basic_beat%0d: got %0h expected %0h", i, got[i], exp_b[i]); end
            checks++; if (got_last[i] !== (i == 3)) begin errors++; $display("[TB] FAIL basic_last%0d: got %b expected %b", i, got_last[i], (i == 3)); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_end: got %b expected 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid_end: got %b expected 0", out_valid); end
    endtask

    task automatic test_duplicate_size;
        logic [511:0] exp_d [4];
        logic         seen;
        int           w;
        exp_d[0] = hdr(8'd0, 7'd4, 7'd1);
        exp_d[1] = {sq(pat(1)), sq(pat(0))};
        exp_d[2] = {sq(pat(3)), sq(pat(2))};
        exp_d[3] = hdr(8'd1, 7'd0, 7'd2);
        write_mem(0, 3, pat(3));
        out_ready = 1'b1;
        do_start(9'd2);
        report(0, 2, 1);
        report(0, 4, 1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen = 1'b1;
            tick;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL dup_early_valid: got %b expected 0", seen); end
        report(1, 0, 2);
        w = 0;
        while (!out_valid && w < 5) begin
            tick;
            w++;
        end
        checks++; if (out_data !== exp_d[0]) begin errors++; $display("[TB] FAIL dup_header: got %0h expected %0h", out_data, exp_d[0]); end
        collect(20);
        checks++; if (got_n != 4) begin errors++; $display("[TB] FAIL dup_beats: got %0d expected 4", got_n); end
        for (int i = 1; i < 4 && i < got_n; i++) begin
            checks++; if (got[i] !== exp_d[i]) begin errors++; $display("[TB] FAIL dup_beat%0d: got %0h expected %0h", i, got[i], exp_d[i]); end
        end
        checks++; if (out_finish !== 1'b1) begin errors++; $display("[TB] FAIL dup_finish: got %b expected 1", out_finish); end
    endtask

    task automatic test_backpressure;
        logic [511:0] exp_p [4];
        logic [511:0] held;
        logic         stalled;
        int           n;
        int           w;
        exp_p[0] = hdr(8'd0, 7'd3, 7'd9);
        exp_p[1] = {sq(pat(1)), sq(pat(0))};
        exp_p[2] = {256'd0, sq(pat(2))};
        exp_p[3] = hdr(8'd1, 7'd0, 7'd5);
        out_ready = 1'b1;
        do_start(9'd2);
        report(0, 3, 9);
        report(1, 0, 5);
        w = 0;
        while (!out_valid && w < 10) begin
            tick;
            w++;
        end
        n       = 0;
        stalled = 1'b0;
        held    = '0;
        for (int c = 0; c < 20; c++) begin
            if (out_finish) break;
            out_ready = (c == 2 || c == 3) ? 1'b0 : 1'b1;
            if (stalled) begin
                checks++; if (out_valid !== 1'b1 || out_data !== held) begin errors++; $display("[TB] FAIL bp_hold_c%0d: got %0h expected %0h", c, out_data, held); end
            end
            if (out_valid && out_ready) begin
                if (n < 4) begin
                    checks++; if (out_data !== exp_p[n]) begin errors++; $display("[TB] FAIL bp_beat%0d: got %0h expected %0h", n, out_data, exp_p[n]); end
                end
                n++;
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
            tick;
        end
        out_ready = 1'b1;
        checks++; if (n != 4) begin errors++; $display("[TB] FAIL bp_beats: got %0d expected 4", n); end
        checks++; if (out_finish !== 1'b1) begin errors++; $display("[TB] FAIL bp_finish: got %b expected 1", out_finish); end
    endtask

    task automatic test_batch_zero;
        logic seen;
        seen = 1'b0;
        do_start(9'd0);
        checks++; if (busy !== 1'b1 || out_finish !== 1'b0) begin errors++; $display("[TB] FAIL zero_started: got busy %b finish %b expected 1 0", busy, out_finish); end
        if (out_valid) seen = 1'b1;
        start      = 1'b1;
        batch_size = 9'd5;
        tick;
        start      = 1'b0;
        checks++; if (out_finish !== 1'b1) begin errors++; $display("[TB] FAIL zero_finish: got %b expected 1", out_finish); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_busy: got %b expected 0", busy); end
        for (int i = 0; i < 5; i++) begin
            if (out_valid) seen = 1'b1;
            tick;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL zero_valid: got %b expected 0", seen); end
        checks++; if (out_finish !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_sticky: got finish %b busy %b expected 1 0", out_finish, busy); end
    endtask

    task automatic test_midstream_reset;
        int w;
        out_ready = 1'b1;
        do_start(9'd2);
        report(0, 3, 9);
        report(1, 0, 5);
        w = 0;
        while (!out_valid && w < 10) begin
            tick;
            w++;
        end
        tick;
        reset_n = 1'b0;
        tick;
        reset_n = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy: got %b expected 0", busy); end
        checks++; if (out_finish !== 1'b0) begin errors++; $display("[TB] FAIL mid_finish: got %b expected 0", out_finish); end
        tick;
        do_start(9'd2);
        report(0, 3, 9);
        report(1, 0, 5);
        collect(20);
        checks++; if (got_n != 4) begin errors++; $display("[TB] FAIL mid_beats: got %0d expected 4", got_n); end
        checks++; if (got[0] !== hdr(8'd0, 7'd3, 7'd9)) begin errors++; $display("[TB] FAIL mid_restart_hdr: got %0h expected %0h", got[0], hdr(8'd0, 7'd3, 7'd9)); end
        checks++; if (got_timeout !== 1'b0) begin errors++; $display("[TB] FAIL mid_timeout: got %b expected 0", got_timeout); end
    endtask

    initial begin
        reset_n      = 1'b0;
        start        = 1'b0;
        batch_size   = '0;
        curr_we      = 1'b0;
        curr_wr_read = '0;
        curr_wr_addr = '0;
        curr_wr_data = '0;
        curr_rd_en   = 1'b0;
        curr_rd_read = '0;
        curr_rd_addr = '0;
        mem_we       = 1'b0;
        mem_rd_en    = 1'b0;
        mem_read     = 8'd3;
        mem_addr     = 7'd5;
        mem_wr_data  = '0;
        size_valid   = 1'b0;
        size_read    = '0;
        size_val     = '0;
        ret_valid    = 1'b0;
        ret_read     = '0;
        ret_val      = '0;
        out_ready    = 1'b0;
        test_reset;
        test_compaction;
        test_basic_stream;
        test_duplicate_size;
        test_backpressure;
        test_batch_zero;
        test_midstream_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
